// File: rtl/program_loader.sv
// Instruction-memory loader: receives a framed byte stream (LEN_HI, LEN_LO, 4*N data bytes, CHK),
// assembles big-endian words, writes them from address 0 and releases the pipeline once the
// XOR checksum matches.
module program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        xor_q, xor_d;
  logic [23:0]       shreg_q, shreg_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic [15:0] len_n;

  assign rx_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                    (state_q == StData)  || (state_q == StCheck);
  assign accept   = rx_valid && rx_ready;
  // Full word count as it becomes known during the LEN_LO byte.
  assign len_n    = {count_q[15:8], rx_data};

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != StDone);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StError);

  // Next-state and datapath updates; everything only moves on an accepted byte.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    shreg_d    = shreg_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (accept) begin
      unique case (state_q)
        StLenHi: begin
          count_d[15:8] = rx_data;
          xor_d         = xor_q ^ rx_data;
          state_d       = StLenLo;
        end
        StLenLo: begin
          count_d[7:0] = rx_data;
          xor_d        = xor_q ^ rx_data;
          if (len_n == 16'd0) begin
            state_d = StCheck;
          end else if (len_n > 16'(DEPTH)) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          xor_d      = xor_q ^ rx_data;
          shreg_d    = {shreg_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {shreg_q, rx_data};
            addr_d     = word_idx_q[ADDR_W-1:0];
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q + 16'd1 == count_q) begin
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          state_d = (rx_data == xor_q) ? StDone : StError;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset also cancels a pending write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLenHi;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      xor_q      <= '0;
      shreg_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      xor_q      <= xor_d;
      shreg_q    <= shreg_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: expected writes are queued as each word's last byte is driven and
// popped by a monitor whenever the loader strobes the instruction memory.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  logic [7:0]  frm[$];
  logic [31:0] wq[$];
  logic [39:0] exp_q[$];

  program_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("stray_we", 32'd1, 32'd0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("waddr", {24'd0, imem_addr}, {24'd0, e[39:32]});
        check("wdata", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    n_writes = 0;
    exp_q    = {};
  endtask

  // Build frm from wq with a length field of n; bad checksum flips bit 0.
  task automatic make_frame(input int n, input bit good);
    logic [7:0] x;
    frm = {};
    frm.push_back(n[15:8]);
    frm.push_back(n[7:0]);
    foreach (wq[i]) begin
      frm.push_back(wq[i][31:24]);
      frm.push_back(wq[i][23:16]);
      frm.push_back(wq[i][15:8]);
      frm.push_back(wq[i][7:0]);
    end
    x = 8'h00;
    foreach (frm[i]) x = x ^ frm[i];
    frm.push_back(good ? x : (x ^ 8'h01));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check("rx_ready_before_byte", {31'd0, rx_ready}, 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Send frm; data bytes are those after the two length bytes and before 2+4*N.
  task automatic send_frame(input int max_gap);
    int n;
    n = {frm[0], frm[1]};
    for (int i = 0; i < frm.size(); i++) begin
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3 && n <= 256) begin
        exp_q.push_back({8'((i - 2) / 4), frm[i-3], frm[i-2], frm[i-1], frm[i]});
      end
      send_byte(frm[i], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
    end
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_end(input string tag, input bit exp_done, input int exp_writes);
    idle(2);
    check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check({tag, "_error"}, {31'd0, error}, {31'd0, !exp_done});
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    check({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_writes"}, n_writes, exp_writes);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();

    // Reset values
    check("rst_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);

    // Test 1: two words, good checksum; hold must drop exactly one cycle after CHK
    wq = '{32'h11223344, 32'h55667788};
    make_frame(2, 1'b1);
    check("t1_chk_value", {24'd0, frm[frm.size()-1]},
          {24'd0, 8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88});
    send_frame(0);
    check("t1_hold_after_chk", {31'd0, cpu_hold}, 32'd0);
    check("t1_done_after_chk", {31'd0, done}, 32'd1);
    check_end("t1", 1'b1, 2);

    // Test 2a: empty frame with good checksum
    do_reset();
    wq = {};
    make_frame(0, 1'b1);
    send_frame(0);
    check_end("t2a", 1'b1, 0);

    // Test 2b: empty frame, CHK=01
    do_reset();
    make_frame(0, 1'b0);
    check("t2b_chk_byte", {24'd0, frm[2]}, 32'h01);
    send_frame(0);
    check_end("t2b", 1'b0, 0);

    // Test 3: one word, wrong checksum; the word is still written
    do_reset();
    wq = '{32'hDEADBEEF};
    make_frame(1, 1'b0);
    send_frame(0);
    check_end("t3", 1'b0, 1);

    // Test 4: length DEPTH+1 errors right after LEN_LO
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t4_error_now", {31'd0, error}, 32'd1);
    check_end("t4", 1'b0, 0);

    // Test 5: test 1 with random gaps
    do_reset();
    wq = '{32'h11223344, 32'h55667788};
    make_frame(2, 1'b1);
    send_frame(5);
    check_end("t5", 1'b1, 2);

    // Test 6: reset on the 3rd data byte of word 1, then replay
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) exp_q.push_back({8'd0, 32'h11223344});
      send_byte(frm[i], 0);
    end
    rx_valid = 1'b1;
    rx_data  = frm[8];
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("t6_first_writes", n_writes, 32'd1);
    check("t6_ready_after_rst", {31'd0, rx_ready}, 32'd1);
    check("t6_wdata_after_rst", imem_wdata, 32'd0);
    n_writes = 0;
    exp_q    = {};
    idle(2);
    send_frame(0);
    check_end("t6", 1'b1, 2);

    // Test 6b: reset coincident with a word's 4th byte cancels the strobe
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(frm[i], 0);
    rx_valid = 1'b1;
    rx_data  = frm[5];
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("t6b_no_we", {31'd0, imem_we}, 32'd0);
    idle(3);
    check("t6b_writes", n_writes, 32'd0);
    check("t6b_addr", {24'd0, imem_addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
